// File: rtl/fun_pipe.sv
// fun_pipe: a two-stage valid/ready pipeline. Each of WIDTH lanes computes
// d = ~(a|b) | (b&c) and e = (b&c) ^ c. In LUT mode, each lane instead looks
// up two programmable 3-input truth tables indexed by {a,b,c}. Stage 2 also
// produces a popcount of d and e. A wrapping counter counts output handshakes.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready is combinational from out_ready)
//   in_mode              0 = gate equations, 1 = LUT lookup (sampled on accept)
//   a, b, c              per-lane operands
//   cfg_we, cfg_d_lut,   write both LUTs at the clock edge
//   cfg_e_lut
//   out_valid/out_ready  output handshake
//   d, e                 per-lane results
//   d_cnt, e_cnt         set-bit counts of d and e
//   beat_cnt             completed output handshakes, wraps at 2^CNT_W
module fun_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PC_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_d_lut,
  input  logic [7:0]       cfg_e_lut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [PC_W-1:0]  d_cnt,
  output logic [PC_W-1:0]  e_cnt,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [7:0]       d_lut_q, d_lut_d;
  logic [7:0]       e_lut_q, e_lut_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_d_q, s1_d_d;
  logic [WIDTH-1:0] s1_e_q, s1_e_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [PC_W-1:0]  d_cnt_q, d_cnt_d;
  logic [PC_W-1:0]  e_cnt_q, e_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             adv1, adv2, accept, out_hs;
  logic [WIDTH-1:0] f_d, f_e;
  logic [2:0]       idx;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) cnt = cnt + PC_W'(v[i]);
    return cnt;
  endfunction

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & in_ready;
  // out_valid is masked during reset so no handshake completes in the reset cycle.
  assign out_valid = s2_valid_q & ~rst;
  assign out_hs    = out_valid & out_ready;

  // Lane function. The LUTs are read before any cfg_we write lands, so a beat
  // accepted in the same cycle as cfg_we uses the old tables.
  always_comb begin
    f_d = '0;
    f_e = '0;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      idx = {a[i], b[i], c[i]};
      if (in_mode) begin
        f_d[i] = d_lut_q[idx];
        f_e[i] = e_lut_q[idx];
      end else begin
        f_d[i] = ~(a[i] | b[i]) | (b[i] & c[i]);
        f_e[i] = (b[i] & c[i]) ^ c[i];
      end
    end
  end

  always_comb begin
    d_lut_d    = d_lut_q;
    e_lut_d    = e_lut_q;
    s1_valid_d = s1_valid_q;
    s1_d_d     = s1_d_q;
    s1_e_d     = s1_e_q;
    s2_valid_d = s2_valid_q;
    d_d        = d_q;
    e_d        = e_q;
    d_cnt_d    = d_cnt_q;
    e_cnt_d    = e_cnt_q;
    beat_cnt_d = beat_cnt_q;

    if (cfg_we) begin
      d_lut_d = cfg_d_lut;
      e_lut_d = cfg_e_lut;
    end

    if (adv1) s1_valid_d = accept;
    if (accept) begin
      s1_d_d = f_d;
      s1_e_d = f_e;
    end

    // Stage-2 data only changes when a real beat moves in, so a stalled
    // output stays stable.
    if (adv2) s2_valid_d = s1_valid_q;
    if (adv2 && s1_valid_q) begin
      d_d     = s1_d_q;
      e_d     = s1_e_q;
      d_cnt_d = popcount(s1_d_q);
      e_cnt_d = popcount(s1_e_q);
    end

    if (out_hs) beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_lut_q    <= 8'h8B;
      e_lut_q    <= 8'h22;
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_e_q     <= '0;
      s2_valid_q <= 1'b0;
      d_q        <= '0;
      e_q        <= '0;
      d_cnt_q    <= '0;
      e_cnt_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      d_lut_q    <= d_lut_d;
      e_lut_q    <= e_lut_d;
      s1_valid_q <= s1_valid_d;
      s1_d_q     <= s1_d_d;
      s1_e_q     <= s1_e_d;
      s2_valid_q <= s2_valid_d;
      d_q        <= d_d;
      e_q        <= e_d;
      d_cnt_q    <= d_cnt_d;
      e_cnt_q    <= e_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign d        = d_q;
  assign e        = e_q;
  assign d_cnt    = d_cnt_q;
  assign e_cnt    = e_cnt_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fun_pipe.sv
// Directed bench for fun_pipe. It covers the reset state, the truth table in
// both modes, LUT reprogramming, backpressure, back-to-back throughput, a
// mid-stream reset, and beat-counter wrap on a CNT_W=4 instance.
module tb_fun_pipe;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_mode, cfg_we, out_ready;
  logic [7:0] a, b, c, cfg_d_lut, cfg_e_lut;
  logic       in_ready, out_valid;
  logic [7:0] d, e;
  logic [3:0] d_cnt, e_cnt;
  logic [15:0] beat_cnt;

  logic       in_ready_w, out_valid_w;
  logic [7:0] d_w, e_w;
  logic [3:0] d_cnt_w, e_cnt_w;
  logic [3:0] beat_cnt_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fun_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .a(a), .b(b), .c(c), .cfg_we(cfg_we),
    .cfg_d_lut(cfg_d_lut), .cfg_e_lut(cfg_e_lut), .out_valid(out_valid),
    .out_ready(out_ready), .d(d), .e(e), .d_cnt(d_cnt), .e_cnt(e_cnt),
    .beat_cnt(beat_cnt)
  );

  fun_pipe #(.WIDTH(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_mode(in_mode), .a(a), .b(b), .c(c), .cfg_we(cfg_we),
    .cfg_d_lut(cfg_d_lut), .cfg_e_lut(cfg_e_lut), .out_valid(out_valid_w),
    .out_ready(out_ready), .d(d_w), .e(e_w), .d_cnt(d_cnt_w), .e_cnt(e_cnt_w),
    .beat_cnt(beat_cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_d(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    return ~(x | y) | (y & z);
  endfunction

  function automatic logic [7:0] ref_e(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    return (y & z) ^ z;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic tt_ops();
    a = 8'hF0; b = 8'hCC; c = 8'hAA;
  endtask

  initial begin
    logic [7:0] ea [$];
    logic [7:0] eb [$];
    logic [7:0] ec [$];
    bit         pat [7];
    logic [7:0] hold_d, hold_e;
    bit         held;
    int         nin, nout, hs;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; cfg_d_lut = '0; cfg_e_lut = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
    check("rst_e", e, 0);
    check("rst_d_cnt", d_cnt, 0);
    check("rst_e_cnt", e_cnt, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Truth table, mode 0.
    in_valid = 1'b1; in_mode = 1'b0; tt_ops();
    step();
    in_valid = 1'b0;
    check("tt0_lat1_valid", out_valid, 0);
    step();
    check("tt0_valid", out_valid, 1);
    check("tt0_d", d, 8'h8B);
    check("tt0_e", e, 8'h22);
    check("tt0_d_cnt", d_cnt, 4);
    check("tt0_e_cnt", e_cnt, 2);
    step();
    check("tt0_beat_cnt", beat_cnt, 1);
    check("tt0_drain", out_valid, 0);

    // Truth table, mode 1 with reset LUTs.
    do_reset();
    in_valid = 1'b1; in_mode = 1'b1; tt_ops();
    step();
    in_valid = 1'b0;
    step();
    check("tt1_valid", out_valid, 1);
    check("tt1_d", d, 8'h8B);
    check("tt1_e", e, 8'h22);
    check("tt1_d_cnt", d_cnt, 4);
    check("tt1_e_cnt", e_cnt, 2);
    step();
    check("tt1_beat_cnt", beat_cnt, 1);

    // LUT reprogram: beat 1 in the write cycle, beat 2 one cycle later.
    do_reset();
    cfg_we = 1'b1; cfg_d_lut = 8'hFF; cfg_e_lut = 8'h01;
    in_valid = 1'b1; in_mode = 1'b1; tt_ops();
    step();
    cfg_we = 1'b0;
    step();
    in_valid = 1'b0;
    check("lut_b1_d", d, 8'h8B);
    check("lut_b1_e", e, 8'h22);
    step();
    check("lut_b2_valid", out_valid, 1);
    check("lut_b2_d", d, 8'hFF);
    check("lut_b2_e", e, 8'h01);
    check("lut_b2_d_cnt", d_cnt, 8);
    check("lut_b2_e_cnt", e_cnt, 1);
    step();
    check("lut_beat_cnt", beat_cnt, 2);

    // Mid-stream reset with two beats in flight; the LUTs still hold FF/01 here.
    in_valid = 1'b1; in_mode = 1'b0; out_ready = 1'b0; tt_ops();
    step();
    step();
    in_valid = 1'b0;
    check("mid_full_valid", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    check("mid_no_hs_in_rst", out_valid, 0);
    step();
    rst = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_beat_cnt", beat_cnt, 0);
    step();
    check("mid_flushed_s1", out_valid, 0);
    in_valid = 1'b1; in_mode = 1'b1; tt_ops();
    step();
    in_valid = 1'b0;
    step();
    check("mid_fresh_valid", out_valid, 1);
    check("mid_fresh_d_lut_reset", d, 8'h8B);
    check("mid_fresh_e_lut_reset", e, 8'h22);
    step();
    check("mid_fresh_beat_cnt", beat_cnt, 1);

    // Backpressure: 6 beats, out_ready pattern 1,0,0,1,0,1,1 then 1.
    do_reset();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ea.delete(); eb.delete(); ec.delete();
    for (int k = 0; k < 6; k++) begin
      ea.push_back(8'(k * 37 + 5));
      eb.push_back(8'(k * 91 + 3));
      ec.push_back(8'(k * 53 + 17));
    end
    nin = 0; nout = 0; held = 1'b0; hold_d = '0; hold_e = '0;
    in_mode = 1'b0;
    for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      out_ready = (cyc < 7) ? pat[cyc] : 1'b1;
      in_valid  = (nin < 6);
      a = ea[nin % 6]; b = eb[nin % 6]; c = ec[nin % 6];
      #1;
      if (cyc == 2) check("bp_in_ready_low", in_ready, 0);
      if (held) begin
        check("bp_hold_d", d, hold_d);
        check("bp_hold_e", e, hold_e);
      end
      if (out_valid) begin
        check("bp_d", d, ref_d(ea[nout], eb[nout], ec[nout]));
        check("bp_e", e, ref_e(ea[nout], eb[nout], ec[nout]));
        check("bp_d_cnt", d_cnt, $countones(ref_d(ea[nout], eb[nout], ec[nout])));
      end
      held = out_valid && !out_ready;
      hold_d = d; hold_e = e;
      if (out_valid && out_ready) nout++;
      if (in_valid && in_ready) nin++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_out", nout, 6);
    check("bp_beat_cnt", beat_cnt, 6);

    // Back-to-back: 16 beats, out_ready held high.
    do_reset();
    ea.delete(); eb.delete(); ec.delete();
    nout = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (cyc < 16);
      if (cyc < 16) begin
        a = 8'(cyc * 29 + 1); b = 8'(cyc * 77 + 9); c = 8'(cyc * 13 + 200);
        ea.push_back(a); eb.push_back(b); ec.push_back(c);
      end
      #1;
      check("tp_out_valid", out_valid, (cyc >= 2 && cyc < 18));
      if (out_valid && nout < 16) begin
        check("tp_d", d, ref_d(ea[nout], eb[nout], ec[nout]));
        check("tp_e", e, ref_e(ea[nout], eb[nout], ec[nout]));
        nout++;
      end
      step();
    end
    check("tp_beat_cnt", beat_cnt, 16);

    // Counter wrap on the CNT_W=4 instance: 17 handshakes.
    do_reset();
    hs = 0;
    tt_ops(); in_mode = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && hs < 17; cyc++) begin
      in_valid = (cyc < 17);
      #1;
      if (out_valid && out_ready) hs++;
      step();
      if (hs == 15) check("wrap_15", beat_cnt_w, 15);
      if (hs == 16) check("wrap_16", beat_cnt_w, 0);
      if (hs == 17) begin
        check("wrap_17", beat_cnt_w, 1);
        check("wrap_wide_17", beat_cnt, 17);
      end
    end
    in_valid = 1'b0;
    check("wrap_hs_total", hs, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fun_pipe.md
Name: fun_pipe

Overview:
- Parametrised, pipelined successor of the team's 3-input/2-output gate function (d = ~(a|b) | (b&c), e = (b&c) ^ c).
- Applies the function bitwise across WIDTH lanes, or an equivalent programmable 3-input LUT per output.
- Adds valid/ready streaming with full throughput and backpressure, per-beat popcounts of d and e, and a wrapping beat counter.
- Sits between a vector data source and downstream logic that consumes d/e masks and their set-bit counts.

Parameters:
- WIDTH, 8, number of independent bit lanes in a, b, c, d, e.
- CNT_W, 16, width of the output beat counter.
- PC_W, $clog2(WIDTH+1), width of the popcount outputs (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  1  per-beat select: 0 = fixed function, 1 = LUT function.
- a  in  WIDTH  operand a, one bit per lane.
- b  in  WIDTH  operand b.
- c  in  WIDTH  operand c.
- cfg_we  in  1  write enable for the LUT registers.
- cfg_d_lut  in  8  new d truth table, indexed by {a,b,c}.
- cfg_e_lut  in  8  new e truth table, indexed by {a,b,c}.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- d  out  WIDTH  d result per lane.
- e  out  WIDTH  e result per lane.
- d_cnt  out  PC_W  number of set bits in d.
- e_cnt  out  PC_W  number of set bits in e.
- beat_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Under rst: out_valid=0, d=0, e=0, d_cnt=0, e_cnt=0, beat_cnt=0, both internal stage-valid flags=0.
  - LUT registers reset to d_lut=8'h8B and e_lut=8'h22, so mode 1 equals mode 0 out of reset.
  - Reset mid-operation drops all in-flight beats; no output handshake occurs in the reset cycle.
- Acceptance:
  - A beat is accepted when in_valid & in_ready.
  - a, b, c and in_mode are sampled only on acceptance.
- Stage 1 (registered):
  - Computes d and e per lane.
  - mode 0 uses the gate equations.
  - mode 1 uses d[i]=d_lut[{a[i],b[i],c[i]}] and e[i]=e_lut[{a[i],b[i],c[i]}].
- Stage 2 (registered):
  - Holds d and e, and computes d_cnt and e_cnt from the stage-1 values.
  - Drives out_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from acceptance to out_valid when unstalled.
  - Throughput is one beat per cycle.
- Flow control:
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1, a combinational path from out_ready, and is low only while both stages are full and out_ready=0.
  - The output is held stable (d, e, d_cnt, e_cnt) while out_valid & ~out_ready.
  - No beat is dropped or duplicated under any out_ready pattern; order is preserved.
- LUT configuration:
  - cfg_we writes both LUTs at the clock edge.
  - A beat accepted in the same cycle as cfg_we uses the old LUT values.
  - Beats accepted later use the new values.
  - Beats already in flight are unaffected.
- Beat counter:
  - beat_cnt increments by 1 on each out_valid & out_ready.
  - Wraps from 2^CNT_W-1 to 0.
  - No saturation, no overflow flag.
- Popcount boundaries: all-ones d gives d_cnt=WIDTH; all-zeros gives 0.
- Simultaneous events:
  - Accept plus output handshake in the same cycle with both stages full moves the pipeline by one with no bubble.
  - cfg_we plus acceptance follows the LUT rule above.
  - rst has priority over everything.
- Inputs present while in_valid=0 have no effect.

Test Plan:
- Exhaustive truth table: WIDTH=8, mode 0, a=8'hF0, b=8'hCC, c=8'hAA, out_ready=1 -> after 2 cycles d=8'h8B, e=8'h22, d_cnt=4, e_cnt=2, beat_cnt=1. The same beat in mode 1 after reset gives identical results.
- LUT reprogram: cfg_we with cfg_d_lut=8'hFF, cfg_e_lut=8'h01, beat accepted in the same cycle, then another beat next cycle, both with the truth-table operands.
  - Beat 1 -> d=8'h8B, e=8'h22.
  - Beat 2 -> d=8'hFF, e=8'h01, d_cnt=8, e_cnt=1.
- Backpressure: stream 6 distinct beats with out_ready pattern 1,0,0,1,0,1,1,...
  - in_ready falls after 2 held beats.
  - Outputs stay stable while stalled.
  - All 6 results emerge in order, with beat_cnt=6.
- Back-to-back throughput: 16 consecutive beats with out_ready=1 -> out_valid high for 16 consecutive cycles starting 2 cycles after the first beat, with no bubbles.
- Reset mid-operation: assert rst for 1 cycle with 2 beats in flight.
  - Next cycle: out_valid=0, beat_cnt=0, LUTs back to 8'h8B/8'h22.
  - A fresh beat completes normally.
- Counter wrap: CNT_W=4, 17 output handshakes -> beat_cnt reads 15 after 15 handshakes, 0 after 16, 1 after 17.
